// File: rtl/wb_arb_pkg.sv
// Shared types and default sizes for the register-file write-port arbiter.
package wb_arb_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 5;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_MC   = 2'd2
    } gnt_sel_e;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry parking register for a multi-cycle result.
// A load that targets r0 is swallowed and leaves the entry empty.
module wb_hold_buf
    import wb_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [ADDR_W-1:0] dest,
    output logic [DATA_W-1:0] data
);

    // Entry register: clear wins, r0 loads are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            dest  <= {ADDR_W{1'b0}};
            data  <= {DATA_W{1'b0}};
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load && (in_dest != {ADDR_W{1'b0}})) begin
            valid <= 1'b1;
            dest  <= in_dest;
            data  <= in_data;
        end else begin
            valid <= valid;
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback first, multi-cycle result parked
// and force-granted after STARVE_MAX losses. Optional macro WB_ARB_STATS_EN adds force_count.
module wb_write_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_dest,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_dest,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    output logic              stall_pipe,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
`ifdef WB_ARB_STATS_EN
    ,output logic [15:0]      force_count
`endif
);

    localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W-1:0] R0      = {ADDR_W{1'b0}};

    arb_state_e        state_r, state_next_s;
    gnt_sel_e          gnt_s;
    logic [CNT_W-1:0]  starve_cnt_r, starve_cnt_next_s;
    logic              pipe_req_s, accept_s, buf_clear_s, buf_valid_s;
    logic [ADDR_W-1:0] buf_dest_s;
    logic [DATA_W-1:0] buf_data_s;

    assign pipe_req_s = pipe_we && (pipe_dest != R0);
    assign accept_s   = mc_valid && !buf_valid_s;
    assign mc_ready   = !buf_valid_s;
    assign stall_pipe = (state_r == FORCE) && pipe_req_s;

    wb_hold_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (accept_s),
        .clear   (buf_clear_s),
        .in_dest (mc_dest),
        .in_data (mc_data),
        .valid   (buf_valid_s),
        .dest    (buf_dest_s),
        .data    (buf_data_s)
    );

    // FSM state and starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= EMPTY;
            starve_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_next_s;
            starve_cnt_r <= starve_cnt_next_s;
        end
    end

    // Next-state, grant select and buffer drain.
    always_comb begin
        state_next_s      = state_r;
        starve_cnt_next_s = starve_cnt_r;
        gnt_s             = GNT_NONE;
        buf_clear_s       = 1'b0;
        case (state_r)
            EMPTY: begin
                if (pipe_req_s) begin
                    gnt_s = GNT_PIPE;
                end else begin
                    gnt_s = GNT_NONE;
                end
                if (accept_s && (mc_dest != R0)) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            WAIT: begin
                if (!pipe_req_s) begin
                    gnt_s             = GNT_MC;
                    buf_clear_s       = 1'b1;
                    starve_cnt_next_s = {CNT_W{1'b0}};
                    state_next_s      = EMPTY;
                end else begin
                    gnt_s = GNT_PIPE;
                    if (starve_cnt_r != CNT_MAX) begin
                        starve_cnt_next_s = starve_cnt_r + CNT_ONE;
                    end else begin
                        starve_cnt_next_s = starve_cnt_r;
                    end
                    // This loss is the STARVE_MAX-th one: force next cycle.
                    if (starve_cnt_r >= (CNT_MAX - CNT_ONE)) begin
                        state_next_s = FORCE;
                    end else begin
                        state_next_s = WAIT;
                    end
                end
            end
            FORCE: begin
                gnt_s             = GNT_MC;
                buf_clear_s       = 1'b1;
                starve_cnt_next_s = {CNT_W{1'b0}};
                state_next_s      = EMPTY;
            end
            default: begin
                gnt_s             = GNT_NONE;
                buf_clear_s       = 1'b1;
                starve_cnt_next_s = {CNT_W{1'b0}};
                state_next_s      = EMPTY;
            end
        endcase
    end

    // Registered RF write port; address and data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= {ADDR_W{1'b0}};
            rf_wdata <= {DATA_W{1'b0}};
        end else begin
            case (gnt_s)
                GNT_PIPE: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= pipe_dest;
                    rf_wdata <= pipe_data;
                end
                GNT_MC: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= buf_dest_s;
                    rf_wdata <= buf_data_s;
                end
                default: begin
                    rf_we <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_ARB_STATS_EN
    // Saturating count of forced-grant cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            force_count <= 16'h0000;
        end else if ((state_r == FORCE) && (force_count != 16'hFFFF)) begin
            force_count <= force_count + 16'h0001;
        end else begin
            force_count <= force_count;
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios plus a randomized run
// against an item-level reference model. Force-count checks need WB_ARB_STATS_EN.
module tb_wb_write_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_dest;
    logic [DATA_W-1:0] pipe_data;
    logic              mc_valid;
    logic [ADDR_W-1:0] mc_dest;
    logic [DATA_W-1:0] mc_data;
    logic              mc_ready;
    logic              stall_pipe;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
`ifdef WB_ARB_STATS_EN
    logic [15:0]       force_count;
`endif

    int checks = 0;
    int errors = 0;

    wb_write_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_dest  (pipe_dest),
        .pipe_data  (pipe_data),
        .mc_valid   (mc_valid),
        .mc_dest    (mc_dest),
        .mc_data    (mc_data),
        .mc_ready   (mc_ready),
        .stall_pipe (stall_pipe),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
`ifdef WB_ARB_STATS_EN
        ,.force_count (force_count)
`endif
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs just after the falling edge.
    task automatic drive(input logic r, input logic we, input logic [ADDR_W-1:0] d,
                         input logic [DATA_W-1:0] dat, input logic mv,
                         input logic [ADDR_W-1:0] md, input logic [DATA_W-1:0] mdat);
        @(negedge clk);
        rst = r; pipe_we = we; pipe_dest = d; pipe_data = dat;
        mc_valid = mv; mc_dest = md; mc_data = mdat;
        #1;
    endtask

    task automatic settle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle();
        drive(1'b1, 1'b1, 5'd4, 32'hFFFF_FFFF, 1'b1, 5'd6, 32'h1);
        settle();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0h exp=0", rf_we); end
        checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got=%0h exp=0", rf_waddr); end
        checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%0h exp=0", rf_wdata); end
        checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0h exp=1", mc_ready); end
        drive(1'b0, 1'b1, 5'd4, 32'h7, 1'b0, 5'd0, 32'd0);
        checks++; if (stall_pipe !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0h exp=0", stall_pipe); end
        settle();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle();
    endtask

    task automatic test_pipe_write;
        drive(1'b0, 1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 32'd0);
        checks++; if (stall_pipe !== 1'b0) begin errors++; $display("FAIL pipe_stall got=%0h exp=0", stall_pipe); end
        settle();
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'hA5})
            begin errors++; $display("FAIL pipe_write got=%0h/%0h/%0h exp=1/3/a5", rf_we, rf_waddr, rf_wdata); end
        drive(1'b0, 1'b0, 5'd8, 32'h77, 1'b0, 5'd0, 32'd0);
        settle();
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd3, 32'hA5})
            begin errors++; $display("FAIL idle_hold got=%0h/%0h/%0h exp=0/3/a5", rf_we, rf_waddr, rf_wdata); end
    endtask

    task automatic test_mc_write;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
        checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL mc_ready_pre got=%0h exp=1", mc_ready); end
        settle();
        checks++; if ({rf_we, mc_ready} !== 2'b00) begin errors++; $display("FAIL mc_accept got we=%0h rdy=%0h exp 0/0", rf_we, mc_ready); end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle();
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h1234})
            begin errors++; $display("FAIL mc_write got=%0h/%0h/%0h exp=1/7/1234", rf_we, rf_waddr, rf_wdata); end
        checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL mc_ready_post got=%0h exp=1", mc_ready); end
    endtask

    task automatic test_force;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
        settle();
        for (int i = 0; i < STARVE_MAX; i++) begin
            drive(1'b0, 1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0);
            checks++; if (stall_pipe !== 1'b0) begin errors++; $display("FAIL starve_stall%0d got=%0h exp=0", i, stall_pipe); end
            settle();
            checks++; if ({rf_we, rf_waddr} !== {1'b1, 5'(10 + i)})
                begin errors++; $display("FAIL starve_grant%0d got=%0h/%0h exp=1/%0h", i, rf_we, rf_waddr, 10 + i); end
        end
        drive(1'b0, 1'b1, 5'd20, 32'h200, 1'b0, 5'd0, 32'd0);
        checks++; if (stall_pipe !== 1'b1) begin errors++; $display("FAIL force_stall got=%0h exp=1", stall_pipe); end
        settle();
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h99})
            begin errors++; $display("FAIL force_write got=%0h/%0h/%0h exp=1/9/99", rf_we, rf_waddr, rf_wdata); end
        drive(1'b0, 1'b1, 5'd20, 32'h200, 1'b0, 5'd0, 32'd0);
        checks++; if (stall_pipe !== 1'b0) begin errors++; $display("FAIL after_force_stall got=%0h exp=0", stall_pipe); end
        settle();
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd20, 32'h200})
            begin errors++; $display("FAIL held_pipe got=%0h/%0h/%0h exp=1/14/200", rf_we, rf_waddr, rf_wdata); end
        checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL force_ready got=%0h exp=1", mc_ready); end
    endtask

    task automatic test_r0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        settle();
        checks++; if ({rf_we, mc_ready} !== 2'b01) begin errors++; $display("FAIL mc_r0 got we=%0h rdy=%0h exp 0/1", rf_we, mc_ready); end
        drive(1'b0, 1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0, 32'd0);
        settle();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL pipe_r0 got=%0h exp=0", rf_we); end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mc_r0_drop got=%0h exp=0", rf_we); end
    endtask

    task automatic test_reset_midop;
        drive(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd5, 32'h55);
        settle();
        checks++; if ({mc_ready, rf_waddr} !== {1'b0, 5'd1}) begin errors++; $display("FAIL midop_load got rdy=%0h addr=%0h exp 0/1", mc_ready, rf_waddr); end
        drive(1'b0, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0);
        settle();
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle();
        checks++; if ({rf_we, rf_waddr, rf_wdata, mc_ready} !== {1'b0, 5'd0, 32'd0, 1'b1})
            begin errors++; $display("FAIL midop_reset got=%0h/%0h/%0h rdy=%0h exp=0/0/0 rdy=1", rf_we, rf_waddr, rf_wdata, mc_ready); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            settle();
            checks++; if ({rf_we, mc_ready} !== 2'b01) begin errors++; $display("FAIL midop_discard%0d got we=%0h rdy=%0h exp 0/1", i, rf_we, mc_ready); end
        end
    endtask

`ifdef WB_ARB_STATS_EN
    task automatic test_stats;
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle();
        checks++; if (force_count !== 16'd0) begin errors++; $display("FAIL stats_reset got=%0d exp=0", force_count); end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'(k));
            settle();
            for (int i = 0; i < STARVE_MAX + 2; i++) begin
                drive(1'b0, 1'b1, 5'd12, 32'(i), 1'b0, 5'd0, 32'd0);
                settle();
            end
        end
        checks++; if (force_count !== 16'd3) begin errors++; $display("FAIL stats_three got=%0d exp=3", force_count); end
    endtask
`endif

    // Randomized run checked against an item-level model of the arbitration rules.
    task automatic test_random;
        logic              r, pw, mv, preq, forced, exp_stall, exp_ready, hold_pipe;
        logic [ADDR_W-1:0] pd, md, m_dest, e_waddr;
        logic [DATA_W-1:0] pdat, mdat, m_data, e_wdata;
        logic              m_valid, e_we;
        int                m_losses, e_fc;
        m_valid = 1'b0; m_losses = 0; m_dest = '0; m_data = '0;
        e_we = 1'b0; e_waddr = '0; e_wdata = '0; e_fc = 0;
        hold_pipe = 1'b0; pw = 1'b0; pd = '0; pdat = '0;
        for (int n = 0; n < 3000; n++) begin
            r = (n < 2) || ($urandom_range(0, 99) == 0);
            if (!hold_pipe) begin
                pw   = ($urandom_range(0, 3) != 0);
                pd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                pdat = $urandom;
            end
            mv   = ($urandom_range(0, 4) < 2);
            md   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            mdat = $urandom;
            drive(r, pw, pd, pdat, mv, md, mdat);

            preq      = pw && (pd != 5'd0);
            exp_ready = !m_valid;
            forced    = m_valid && (m_losses >= STARVE_MAX);
            exp_stall = forced && preq;
            checks++; if (mc_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready@%0d got=%0h exp=%0h", n, mc_ready, exp_ready); end
            checks++; if (stall_pipe !== exp_stall) begin errors++; $display("FAIL rnd_stall@%0d got=%0h exp=%0h", n, stall_pipe, exp_stall); end

            if (r) begin
                m_valid = 1'b0; m_losses = 0;
                e_we = 1'b0; e_waddr = '0; e_wdata = '0; e_fc = 0;
            end else begin
                if (forced || (m_valid && !preq)) begin
                    e_we = 1'b1; e_waddr = m_dest; e_wdata = m_data;
                    m_valid = 1'b0; m_losses = 0;
                    if (forced && e_fc < 65535) e_fc++;
                end else if (preq) begin
                    e_we = 1'b1; e_waddr = pd; e_wdata = pdat;
                    if (m_valid) m_losses++;
                end else begin
                    e_we = 1'b0;
                end
                if (exp_ready && mv && (md != 5'd0)) begin
                    m_valid = 1'b1; m_dest = md; m_data = mdat; m_losses = 0;
                end
            end
            hold_pipe = exp_stall && !r;

            settle();
            checks++; if ({rf_we, rf_waddr, rf_wdata} !== {e_we, e_waddr, e_wdata})
                begin errors++; $display("FAIL rnd_rf@%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", n, rf_we, rf_waddr, rf_wdata, e_we, e_waddr, e_wdata); end
`ifdef WB_ARB_STATS_EN
            checks++; if (force_count !== 16'(e_fc)) begin errors++; $display("FAIL rnd_fc@%0d got=%0d exp=%0d", n, force_count, e_fc); end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; pipe_we = 1'b0; pipe_dest = '0; pipe_data = '0;
        mc_valid = 1'b0; mc_dest = '0; mc_data = '0;
        test_reset();
        test_pipe_write();
        test_mc_write();
        test_force();
        test_r0();
        test_reset_midop();
`ifdef WB_ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
